// File: rtl/tcam_lookup_if.sv
// Request/response bundle for the TCAM lookup block: entry writes, flush, search
// requests, and the registered search results and entry count.
interface tcam_lookup_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int IW = $clog2(DEPTH);

  logic                  wr_en;
  logic [IW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic                  wr_vld;
  logic                  flush;
  logic                  srch_vld;
  logic [DATA_WIDTH-1:0] srch_key;
  logic                  rslt_vld;
  logic                  rslt_hit;
  logic [IW-1:0]         rslt_idx;
  logic                  rslt_multi;
  logic [IW:0]           entry_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, wr_mask, wr_vld, flush, srch_vld, srch_key,
    input  rslt_vld, rslt_hit, rslt_idx, rslt_multi, entry_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_mask, wr_vld, flush, srch_vld, srch_key,
    output rslt_vld, rslt_hit, rslt_idx, rslt_multi, entry_cnt
  );
endinterface

// File: rtl/tcam_lookup.sv
// Register-based ternary CAM: parallel compare of the key against all entries,
// match vector registered in stage 1, priority-encoded result registered in stage 2.
module tcam_lookup #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int TERNARY    = 1
) (
  input logic          clk,
  input logic          rst,
  tcam_lookup_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [DATA_WIDTH-1:0] MASK_EN = (TERNARY != 0) ? {DATA_WIDTH{1'b1}} : '0;

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] mask_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH-1:0]      valid_nxt;
  logic [IW:0]           cnt_q;
  logic [IW:0]           cnt_nxt;

  logic [DEPTH-1:0]      match;
  logic                  s1_vld;
  logic [DEPTH-1:0]      s1_match;

  logic [IW-1:0]         enc_idx;
  logic                  enc_multi;
  logic                  rslt_vld_q;
  logic                  rslt_hit_q;
  logic [IW-1:0]         rslt_idx_q;
  logic                  rslt_multi_q;

  logic                  wr_take;

  // flush wins over a concurrent write; the write is discarded entirely
  assign wr_take = bus.wr_en && !bus.flush;

  always_comb begin
    valid_nxt = valid_q;
    if (bus.flush) begin
      valid_nxt = '0;
    end else if (bus.wr_en) begin
      valid_nxt[bus.wr_addr] = bus.wr_vld;
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + {{IW{1'b0}}, valid_nxt[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (wr_take) begin
        data_q[bus.wr_addr] <= bus.wr_data;
        mask_q[bus.wr_addr] <= bus.wr_mask;
      end
      valid_q <= valid_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // compares against current (pre-write) contents; a same-cycle write lands at the edge
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] &&
                 (((bus.srch_key ^ data_q[i]) & ~(mask_q[i] & MASK_EN)) == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_match <= '0;
    end else begin
      s1_vld <= bus.srch_vld;
      if (bus.srch_vld) begin
        s1_match <= match;
      end
    end
  end

  always_comb begin
    enc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (s1_match[i]) begin
        enc_idx = IW'(i);
      end
    end
  end

  // clearing the lowest set bit leaves something only when two or more bits were set
  assign enc_multi = |(s1_match & (s1_match - DEPTH'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rslt_vld_q   <= 1'b0;
      rslt_hit_q   <= 1'b0;
      rslt_idx_q   <= '0;
      rslt_multi_q <= 1'b0;
    end else begin
      rslt_vld_q <= s1_vld;
      if (s1_vld) begin
        rslt_hit_q   <= |s1_match;
        rslt_idx_q   <= enc_idx;
        rslt_multi_q <= enc_multi;
      end
    end
  end

  assign bus.rslt_vld   = rslt_vld_q;
  assign bus.rslt_hit   = rslt_hit_q;
  assign bus.rslt_idx   = rslt_idx_q;
  assign bus.rslt_multi = rslt_multi_q;
  assign bus.entry_cnt  = cnt_q;
endmodule

// File: tb/tb_tcam_lookup.sv
// Directed bench for tcam_lookup: hand-computed vectors for lookup, priority,
// write/search ordering, flush, invalidation and reset behaviour.
module tb_tcam_lookup;
  localparam int DW = 8;
  localparam int DP = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  tcam_lookup_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

  tcam_lookup #(.DATA_WIDTH(DW), .DEPTH(DP), .TERNARY(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_rslt(input string tag, input logic vld, input logic hit,
                            input int idx, input logic multi);
    check({tag, ".vld"},   32'(bus.rslt_vld),   32'(vld));
    check({tag, ".hit"},   32'(bus.rslt_hit),   32'(hit));
    check({tag, ".idx"},   32'(bus.rslt_idx),   32'(idx));
    check({tag, ".multi"}, 32'(bus.rslt_multi), 32'(multi));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int addr, input logic [7:0] d, input logic [7:0] m, input logic v);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'(addr);
    bus.wr_data = d;
    bus.wr_mask = m;
    bus.wr_vld  = v;
  endtask

  task automatic write_entry(input int addr, input logic [7:0] d, input logic [7:0] m, input logic v);
    set_wr(addr, d, m, v);
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic search(input string tag, input logic [7:0] key, input logic hit,
                        input int idx, input logic multi);
    bus.srch_vld = 1'b1;
    bus.srch_key = key;
    step();
    bus.srch_vld = 1'b0;
    check({tag, ".lat1"}, 32'(bus.rslt_vld), 32'(0));
    step();
    check_rslt(tag, 1'b1, hit, idx, multi);
  endtask

  initial begin
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_mask  = '0;
    bus.wr_vld   = 1'b0;
    bus.flush    = 1'b0;
    bus.srch_vld = 1'b0;
    bus.srch_key = '0;

    step();
    step();
    check_rslt("rst", 1'b0, 1'b0, 0, 1'b0);
    check("rst.cnt", 32'(bus.entry_cnt), 32'(0));
    rst = 1'b0;
    step();
    check("rst.idle", 32'(bus.rslt_vld), 32'(0));

    search("empty", 8'h00, 1'b0, 0, 1'b0);
    check("empty.cnt", 32'(bus.entry_cnt), 32'(0));

    write_entry(3, 8'hA5, 8'h00, 1'b1);
    check("wr3.cnt", 32'(bus.entry_cnt), 32'(1));
    write_entry(7, 8'hA0, 8'h0F, 1'b1);
    check("wr7.cnt", 32'(bus.entry_cnt), 32'(2));
    search("a5", 8'hA5, 1'b1, 3, 1'b1);
    search("ac", 8'hAC, 1'b1, 7, 1'b0);
    step();
    check_rslt("hold", 1'b0, 1'b1, 7, 1'b0);

    // write and search in the same cycle, then the same search again right after
    set_wr(5, 8'h3C, 8'h00, 1'b1);
    bus.srch_vld = 1'b1;
    bus.srch_key = 8'h3C;
    step();
    bus.wr_en = 1'b0;
    step();
    bus.srch_vld = 1'b0;
    check_rslt("samecyc", 1'b1, 1'b0, 0, 1'b0);
    step();
    check_rslt("nextcyc", 1'b1, 1'b1, 5, 1'b0);
    check("wr5.cnt", 32'(bus.entry_cnt), 32'(3));

    // back-to-back stream
    bus.srch_vld = 1'b1;
    bus.srch_key = 8'hA5;
    step();
    bus.srch_key = 8'h11;
    step();
    check_rslt("s0", 1'b1, 1'b1, 3, 1'b1);
    bus.srch_key = 8'hAC;
    step();
    check_rslt("s1", 1'b1, 1'b0, 0, 1'b0);
    bus.srch_vld = 1'b0;
    step();
    check_rslt("s2", 1'b1, 1'b1, 7, 1'b0);
    step();
    check("s.end", 32'(bus.rslt_vld), 32'(0));

    write_entry(5, 8'h3C, 8'h00, 1'b1);
    check("rewr.cnt", 32'(bus.entry_cnt), 32'(3));

    // write lands while the search sits in stage 1
    bus.srch_vld = 1'b1;
    bus.srch_key = 8'h3C;
    step();
    bus.srch_vld = 1'b0;
    set_wr(5, 8'h77, 8'h00, 1'b1);
    step();
    bus.wr_en = 1'b0;
    check_rslt("inflight", 1'b1, 1'b1, 5, 1'b0);
    search("old3c", 8'h3C, 1'b0, 0, 1'b0);
    search("new77", 8'h77, 1'b1, 5, 1'b0);
    check("inflt.cnt", 32'(bus.entry_cnt), 32'(3));

    write_entry(15, 8'hEE, 8'h00, 1'b1);
    check("wr15.cnt", 32'(bus.entry_cnt), 32'(4));
    search("top", 8'hEE, 1'b1, 15, 1'b0);
    write_entry(1, 8'h00, 8'hFF, 1'b1);
    check("wr1.cnt", 32'(bus.entry_cnt), 32'(5));
    search("wild_ee", 8'hEE, 1'b1, 1, 1'b1);
    search("wild_3c", 8'h3C, 1'b1, 1, 1'b0);

    // flush beats a concurrent write
    bus.flush = 1'b1;
    set_wr(0, 8'h55, 8'h00, 1'b1);
    step();
    bus.flush = 1'b0;
    bus.wr_en = 1'b0;
    check("flush.cnt", 32'(bus.entry_cnt), 32'(0));
    search("flush55", 8'h55, 1'b0, 0, 1'b0);

    write_entry(3, 8'hA5, 8'h00, 1'b1);
    write_entry(7, 8'hA0, 8'h0F, 1'b1);
    check("refill.cnt", 32'(bus.entry_cnt), 32'(2));
    write_entry(3, 8'hA5, 8'h00, 1'b0);
    check("inval.cnt", 32'(bus.entry_cnt), 32'(1));
    search("inval", 8'hA5, 1'b1, 7, 1'b0);

    // reset one cycle after a search issue
    bus.srch_vld = 1'b1;
    bus.srch_key = 8'hA5;
    step();
    bus.srch_vld = 1'b0;
    rst = 1'b1;
    #1;
    check_rslt("rstmid0", 1'b0, 1'b0, 0, 1'b0);
    step();
    check_rslt("rstmid1", 1'b0, 1'b0, 0, 1'b0);
    check("rstmid.cnt", 32'(bus.entry_cnt), 32'(0));
    step();
    rst = 1'b0;
    step();
    check("rstpost0", 32'(bus.rslt_vld), 32'(0));
    step();
    check("rstpost1", 32'(bus.rslt_vld), 32'(0));
    search("postrst", 8'hA5, 1'b0, 0, 1'b0);
    check("postrst.cnt", 32'(bus.entry_cnt), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/tcam_lookup.md
TCAM_LOOKUP -- requirements
Module: tcam_lookup

Interface
REQ-001 Parameter DATA_WIDTH, default 8, key/entry width in bits.
REQ-002 Parameter DEPTH, default 16, number of entries (power of two, >=2); IW = $clog2(DEPTH).
REQ-003 Parameter TERNARY, default 1, 1 = per-bit don't-care masking enabled, 0 = exact match only.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 wr_en  input  1  write strobe for entry wr_addr.
REQ-007 wr_addr  input  IW  entry index to write.
REQ-008 wr_data  input  DATA_WIDTH  stored pattern.
REQ-009 wr_mask  input  DATA_WIDTH  don't-care bits (1 = ignore bit); ignored when TERNARY=0.
REQ-010 wr_vld  input  1  valid bit written with the entry (0 = invalidate entry).
REQ-011 flush  input  1  invalidate all entries.
REQ-012 srch_vld  input  1  search request strobe.
REQ-013 srch_key  input  DATA_WIDTH  search key.
REQ-014 rslt_vld  output  1  result strobe, one cycle per accepted search.
REQ-015 rslt_hit  output  1  at least one valid entry matched.
REQ-016 rslt_idx  output  IW  lowest matching index; 0 when no hit.
REQ-017 rslt_multi  output  1  two or more entries matched.
REQ-018 entry_cnt  output  IW+1  number of valid entries.

Function
REQ-019 Entry i SHALL match when valid[i]=1 and ((srch_key ^ data[i]) & ~mask[i]) == 0; with TERNARY=0, mask SHALL be treated as all zeros.
REQ-020 Search SHALL be a 2-stage pipeline: stage 1 registers the DEPTH-bit match vector, stage 2 registers priority-encoded results; search sampled in cycle N produces rslt_vld in cycle N+2.
REQ-021 One search SHALL be accepted every cycle; no backpressure; back-to-back results SHALL appear in issue order.
REQ-022 rslt_vld SHALL be 0 in any cycle without a corresponding search; rslt_hit/rslt_idx/rslt_multi SHALL hold their last values when rslt_vld=0.
REQ-023 Priority SHALL be lowest index wins; rslt_multi SHALL be 1 exactly when popcount(match vector) >= 2.
REQ-024 Write SHALL update data, mask and valid of entry wr_addr at the clock edge; a search sampled in the same cycle as a write SHALL compare against pre-write contents; a search one cycle later SHALL see the new contents.
REQ-025 flush SHALL clear all valid bits at the edge, leaving data/mask unchanged; flush and wr_en in the same cycle: flush wins, write discarded.
REQ-026 Searches already in the pipeline when a write or flush occurs SHALL complete with their original stage-1 match vector.
REQ-027 entry_cnt SHALL be registered and reflect valid bits after the edge that changed them (same cycle as the new contents become visible); rewriting a valid entry with wr_vld=1 SHALL not change the count.
REQ-028 Search with all entries invalid SHALL return rslt_hit=0, rslt_idx=0, rslt_multi=0.

Reset
REQ-029 On rst: all valid bits 0, all data and mask 0, pipeline stages cleared (in-flight searches dropped), rslt_vld=0, rslt_hit=0, rslt_idx=0, rslt_multi=0, entry_cnt=0.
REQ-030 Entries SHALL not be preloaded; first functional search after reset returns no hit until written.
REQ-031 Reset asserted mid-pipeline SHALL suppress rslt_vld for any search issued before or during reset.

Verification (defaults DATA_WIDTH=8, DEPTH=16, TERNARY=1)
REQ-032 After reset, search key 0x00 -> cycle+2 rslt_vld=1, rslt_hit=0, rslt_idx=0, entry_cnt=0.
REQ-033 Write idx3=0xA5 mask 0x00, idx7=0xA0 mask 0x0F; search 0xA5 -> hit=1, idx=3, multi=1; search 0xAC -> hit=1, idx=7, multi=0; entry_cnt=2.
REQ-034 Same-cycle write idx5=0x3C and search 0x3C -> miss; search 0x3C next cycle -> hit, idx=5.
REQ-035 Searches 0xA5, 0x11, 0xAC on consecutive cycles -> three consecutive rslt_vld pulses with hit/miss/hit in order.
REQ-036 Flush with simultaneous wr_en idx0=0x55 -> entry_cnt=0, search 0x55 misses; invalidate idx3 via wr_vld=0 -> entry_cnt decrements by 1.
REQ-037 Reset asserted one cycle after a search issue -> no rslt_vld for that search; all outputs 0.
